// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: ROM address/data, instruction hand-off to execute, branch redirect.
// The fetch stage uses the master view; the execute stage and ROM side use the slave view.
interface instruction_fetch_if;
    logic [7:0] address_bus;
    logic [7:0] data_bus;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic       instr_len2;
    logic [7:0] instr_pc;
    logic       branch_taken;
    logic [7:0] branch_target;

    modport master (
        output address_bus, instr_valid, instr_opcode, instr_operand, instr_len2, instr_pc,
        input  data_bus, instr_ready, branch_taken, branch_target
    );

    modport slave (
        input  address_bus, instr_valid, instr_opcode, instr_operand, instr_len2, instr_pc,
        output data_bus, instr_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: assembles 1/2-byte instructions from a combinational ROM
// into a holding register and hands them to execute over valid/ready, with branch redirect.
module instruction_fetch (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {FETCH1, FETCH2, HOLD} state_t;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [7:0] op_pc;
    logic       len2;
    logic       valid;

    // Branches (101x_xxxx), MOV_IMM (1000_00xx) and CMP_IMM (1000_11xx) carry an operand byte.
    function automatic logic is_two_byte(input logic [7:0] b);
        return (b[7:5] == 3'b101) || (b[7:2] == 6'b100000) || (b[7:2] == 6'b100011);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH1;
            pc      <= 8'h00;
            opcode  <= 8'h00;
            operand <= 8'h00;
            op_pc   <= 8'h00;
            len2    <= 1'b0;
            valid   <= 1'b0;
        end else if (bus.branch_taken) begin
            // Redirect wins over everything, including a transfer on the same edge.
            state <= FETCH1;
            pc    <= bus.branch_target;
            valid <= 1'b0;
        end else begin
            case (state)
                FETCH1: begin
                    opcode <= bus.data_bus;
                    op_pc  <= pc;
                    pc     <= pc + 8'd1;
                    if (is_two_byte(bus.data_bus)) begin
                        state <= FETCH2;
                    end else begin
                        operand <= 8'h00;
                        len2    <= 1'b0;
                        state   <= HOLD;
                        valid   <= 1'b1;
                    end
                end
                FETCH2: begin
                    operand <= bus.data_bus;
                    len2    <= 1'b1;
                    pc      <= pc + 8'd1;
                    state   <= HOLD;
                    valid   <= 1'b1;
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        state <= FETCH1;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH1;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.address_bus   = pc;
    assign bus.instr_valid   = valid;
    assign bus.instr_opcode  = opcode;
    assign bus.instr_operand = operand;
    assign bus.instr_len2    = len2;
    assign bus.instr_pc      = op_pc;
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage placed directly downstream of `program_memory`. It drives the ROM `address_bus` from an 8-bit program counter and reads `data_bus` one byte per cycle. It assembles 1- or 2-byte instructions into a holding register and hands them to the execute stage over a valid/ready handshake. It also accepts PC redirects from taken branches.

## Interface
- No parameters. Address and data widths are fixed at 8 bits to match `program_memory`.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `address_bus`  out  8  ROM byte address. Always equals the current PC, combinationally.
- `data_bus`  in  8  ROM read data. Valid in the same cycle as `address_bus` (combinational ROM read).
- `instr_valid`  out  1  holding register contains an instruction.
- `instr_ready`  in  1  execute stage accepts the instruction this cycle.
- `instr_opcode`  out  8  first instruction byte.
- `instr_operand`  out  8  second byte. 8'h00 for 1-byte instructions.
- `instr_len2`  out  1  1 when the instruction is 2 bytes long.
- `instr_pc`  out  8  address of `instr_opcode`.
- `branch_taken`  in  1  single-cycle redirect request from execute.
- `branch_target`  in  8  new PC. Sampled only when `branch_taken`=1.

## Operation
- **Length decode** (on the first byte b): the instruction is 2 bytes iff any of the following hold. Every other byte is a 1-byte instruction, including 8'h70 NOP.
  - b[7:5]==3'b101 (branches: BRA, BHI, BEQ).
  - b[7:2]==6'b100000 (MOV_IMM).
  - b[7:2]==6'b100011 (CMP_IMM).
- **States:** FETCH1, FETCH2, HOLD.
- **FETCH1:** at the clock edge, capture `data_bus` into opcode, set `instr_pc` to the PC, PC <= PC+1.
  - If 2-byte: go to FETCH2.
  - If 1-byte: clear operand, set len2=0, go to HOLD.
- **FETCH2:** at the clock edge, capture `data_bus` into operand, set len2=1, PC <= PC+1, go to HOLD.
- **HOLD:** `instr_valid`=1.
  - A transfer occurs on the edge where `instr_valid`&&`instr_ready`; the next state is then FETCH1.
  - While `instr_ready`=0: all `instr_*` outputs and the PC are held stable, and no new byte is captured.
- `instr_valid` is a registered output, equal to (state==HOLD).
- **PC arithmetic:** modulo 256. 8'hFF+1 = 8'h00. A 2-byte instruction at 8'hFF takes its operand from address 8'h00.
- **Branch redirect** (any state): at the edge where `branch_taken`=1, PC <= `branch_target` and state <= FETCH1.
  - Any partially fetched or held instruction is discarded, and `instr_valid` is 0 after that edge.
  - If a transfer coincides with `branch_taken`, the transfer still counts as accepted and the redirect wins for the PC.
- **Reset** (asynchronous, any time, including mid-instruction): the following take effect immediately and hold while `reset`=1.
  - PC=8'h00, so `address_bus`=8'h00.
  - State=FETCH1.
  - `instr_valid`=0.
  - `instr_opcode`, `instr_operand`, `instr_pc` = 8'h00; `instr_len2`=0.

## Timing
- No instruction overlap and no prefetch: the next FETCH1 begins only after a transfer or a redirect.
- Latency from entering FETCH1 to `instr_valid`=1: 1 cycle for a 1-byte instruction, 2 cycles for a 2-byte instruction.
- Throughput with `instr_ready` tied high: one 1-byte instruction per 2 cycles, one 2-byte instruction per 3 cycles.
- The `branch_target` PC appears on `address_bus` in the cycle immediately after the `branch_taken` edge.
- `address_bus` changes only on clock edges or on reset assertion. It is glitch-free with respect to the inputs.

## Test plan
- **Fetch sequence.** ROM[0..4] = 81,00,82,00,98 (hex); release reset; `instr_ready`=1. Required response:
  - (pc=00, op=81, operand=00, len2=1) valid after edge 2.
  - (pc=02, op=82, operand=00, len2=1) valid after edge 5.
  - (pc=04, op=98, operand=00, len2=0) valid after edge 7.
- **Stall.** Hold `instr_ready`=0 for 5 cycles while (pc=04, op=98) is valid. Required: outputs and `address_bus`=05 stay constant throughout. On `instr_ready`=1, the next instruction is fetched from 05.
- **Branch from HOLD.** ROM[0B..0C] = A8,04. When (op=A8, operand=04) is valid, assert `instr_ready` and `branch_taken` with target 04 together. Required: `instr_valid`=0 and `address_bus`=04 next cycle, then the instruction at 04 is delivered.
- **Branch in FETCH2.** Assert `branch_taken` (target 10) during FETCH2 of 81 at address 00. Required: the operand is not delivered, no `instr_valid` pulse for pc=00, and the next fetch is at address 10.
- **Wrap-around.** ROM[FF]=81, ROM[00]=2A, branch to FF. Required: (pc=FF, op=81, operand=2A, len2=1) is delivered, and the next PC is 01.
- **Asynchronous reset.** Assert `reset` between clock edges while in HOLD. Required: `instr_valid`=0 and `address_bus`=00 immediately, without waiting for a clock edge. After release, fetching restarts from 00.
